// File: rtl/weight_fetch_controller.sv
// weight_fetch_controller
// Reads packed weight/bias words from external memory in bursts and forwards
// each returned beat to the weight buffer one cycle later. Only one burst is
// outstanding at a time. A new burst is requested only while the weight buffer
// reports room for at least one more full burst.
module weight_fetch_controller #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_DATA_WIDTH = 512,
  parameter int BURST_LEN      = 64,
  parameter int LEN_WIDTH      = 8,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                      system_clk,
  input  logic                      system_rst,
  // task control from the layer scheduler
  input  logic                      start,
  input  logic [ADDR_WIDTH-1:0]     base_addr,
  input  logic [CNT_WIDTH-1:0]      word_count,
  output logic                      busy,
  output logic                      done,
  output logic                      protocol_error,
  // memory read request channel
  output logic                      rd_req_valid,
  input  logic                      rd_req_ready,
  output logic [ADDR_WIDTH-1:0]     rd_req_addr,
  output logic [LEN_WIDTH-1:0]      rd_req_len,
  // memory read data channel (no backpressure)
  input  logic [MEM_DATA_WIDTH-1:0] rd_data,
  input  logic                      rd_data_valid,
  input  logic                      rd_data_last,
  // weight buffer write port
  output logic [MEM_DATA_WIDTH-1:0] weight_and_bias_data,
  output logic                      weight_and_bias_valid,
  input  logic                      weight_buffer_ready
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [CNT_WIDTH-1:0]  BURST_MAX      = CNT_WIDTH'(BURST_LEN);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE        = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] BYTES_PER_WORD = ADDR_WIDTH'(MEM_DATA_WIDTH / 8);

  logic [1:0]                state_reg;
  logic [ADDR_WIDTH-1:0]     cur_addr_reg;
  logic [CNT_WIDTH-1:0]      remaining_reg;
  logic [CNT_WIDTH-1:0]      burst_reg;
  logic [CNT_WIDTH-1:0]      beat_cnt_reg;
  logic                      protocol_error_reg;
  logic                      rd_req_valid_reg;
  logic [ADDR_WIDTH-1:0]     rd_req_addr_reg;
  logic [LEN_WIDTH-1:0]      rd_req_len_reg;
  logic [MEM_DATA_WIDTH-1:0] wb_data_reg;
  logic                      wb_valid_reg;

  logic [CNT_WIDTH-1:0]      burst_next;
  logic                      closing_beat;

  // Size of the next burst: a full burst, or whatever is left of the task.
  assign burst_next   = (remaining_reg > BURST_MAX) ? BURST_MAX : remaining_reg;
  // The beat count alone decides where a burst ends; rd_data_last is only checked.
  assign closing_beat = (beat_cnt_reg == (burst_reg - CNT_ONE));

  assign busy                  = (state_reg != ST_IDLE);
  assign done                  = (state_reg == ST_DONE);
  assign protocol_error        = protocol_error_reg;
  assign rd_req_valid          = rd_req_valid_reg;
  assign rd_req_addr           = rd_req_addr_reg;
  assign rd_req_len            = rd_req_len_reg;
  assign weight_and_bias_data  = wb_data_reg;
  assign weight_and_bias_valid = wb_valid_reg;

  // Task FSM, burst request generation and one-cycle beat forwarding.
  always_ff @(posedge system_clk) begin
    if (system_rst) begin
      state_reg          <= ST_IDLE;
      cur_addr_reg       <= '0;
      remaining_reg      <= '0;
      burst_reg          <= '0;
      beat_cnt_reg       <= '0;
      protocol_error_reg <= 1'b0;
      rd_req_valid_reg   <= 1'b0;
      rd_req_addr_reg    <= '0;
      rd_req_len_reg     <= '0;
      wb_data_reg        <= '0;
      wb_valid_reg       <= 1'b0;
    end else begin
      wb_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            cur_addr_reg       <= base_addr;
            remaining_reg      <= word_count;
            protocol_error_reg <= 1'b0;
            state_reg          <= (word_count == '0) ? ST_DONE : ST_REQ;
          end
          // A stray beat with no burst outstanding is dropped and flagged;
          // the flag wins over the clear from a coincident start.
          if (rd_data_valid) begin
            protocol_error_reg <= 1'b1;
          end
        end

        ST_REQ: begin
          if (rd_data_valid) begin
            protocol_error_reg <= 1'b1;
          end
          if (!rd_req_valid_reg) begin
            // Buffer room is only consulted before raising a request; once
            // raised, the request stays put until memory takes it.
            if (weight_buffer_ready) begin
              rd_req_valid_reg <= 1'b1;
              rd_req_addr_reg  <= cur_addr_reg;
              rd_req_len_reg   <= LEN_WIDTH'(burst_next - CNT_ONE);
              burst_reg        <= burst_next;
            end
          end else if (rd_req_ready) begin
            rd_req_valid_reg <= 1'b0;
            beat_cnt_reg     <= '0;
            state_reg        <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (rd_data_valid) begin
            wb_data_reg  <= rd_data;
            wb_valid_reg <= 1'b1;
            beat_cnt_reg <= beat_cnt_reg + CNT_ONE;
            if (rd_data_last != closing_beat) begin
              protocol_error_reg <= 1'b1;
            end
            if (closing_beat) begin
              remaining_reg <= remaining_reg - burst_reg;
              cur_addr_reg  <= cur_addr_reg + (ADDR_WIDTH'(burst_reg) * BYTES_PER_WORD);
              state_reg     <= (remaining_reg == burst_reg) ? ST_DONE : ST_REQ;
            end
          end
        end

        ST_DONE: begin
          if (rd_data_valid) begin
            protocol_error_reg <= 1'b1;
          end
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_weight_fetch_controller.sv
// tb_weight_fetch_controller
// Scoreboard bench: expected burst requests are queued when a task is started,
// expected data words are queued when the memory model drives a beat, and both
// are popped and compared as the controller produces them.
module tb_weight_fetch_controller;

  logic         system_clk = 1'b0;
  logic         system_rst;
  logic         start;
  logic [31:0]  base_addr;
  logic [23:0]  word_count;
  logic         busy;
  logic         done;
  logic         protocol_error;
  logic         rd_req_valid;
  logic         rd_req_ready;
  logic [31:0]  rd_req_addr;
  logic [7:0]   rd_req_len;
  logic [511:0] rd_data;
  logic         rd_data_valid;
  logic         rd_data_last;
  logic [511:0] weight_and_bias_data;
  logic         weight_and_bias_valid;
  logic         weight_buffer_ready;

  weight_fetch_controller dut (
    .system_clk            (system_clk),
    .system_rst            (system_rst),
    .start                 (start),
    .base_addr             (base_addr),
    .word_count            (word_count),
    .busy                  (busy),
    .done                  (done),
    .protocol_error        (protocol_error),
    .rd_req_valid          (rd_req_valid),
    .rd_req_ready          (rd_req_ready),
    .rd_req_addr           (rd_req_addr),
    .rd_req_len            (rd_req_len),
    .rd_data               (rd_data),
    .rd_data_valid         (rd_data_valid),
    .rd_data_last          (rd_data_last),
    .weight_and_bias_data  (weight_and_bias_data),
    .weight_and_bias_valid (weight_and_bias_valid),
    .weight_buffer_ready   (weight_buffer_ready)
  );

  always #5 system_clk = ~system_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [39:0]  exp_req[$];   // {addr, len}
  logic [511:0] exp_data[$];

  int wb_beats    = 0;
  int done_count  = 0;
  int stall_once  = 0;        // cycles to hold off rd_req_ready on the next request
  int early_last  = -1;       // beat index carrying rd_data_last, -1 = normal
  bit abort       = 1'b0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_word();
    logic [511:0] w;
    for (int i = 0; i < 16; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Output monitor: pop expected data on every buffer write.
  always @(negedge system_clk) begin
    if (weight_and_bias_valid) begin
      wb_beats++;
      if (exp_data.size() == 0) check_eq("wb_extra_beat", weight_and_bias_valid, 1'b0);
      else                      check_eq("wb_data", weight_and_bias_data, exp_data.pop_front());
    end
    if (done) done_count++;
  end

  // Memory model: accepts one request, then returns its beats with random gaps.
  initial begin : responder
    logic [39:0] er;
    logic [31:0] a_cap;
    logic [7:0]  l_cap;
    logic [511:0] d;
    int n;
    rd_req_ready  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    rd_data_last  = 1'b0;
    forever begin
      @(negedge system_clk);
      if (!abort && rd_req_valid) begin
        if (exp_req.size() == 0) check_eq("req_extra", rd_req_valid, 1'b0);
        else begin
          er = exp_req.pop_front();
          check_eq("req_addr", rd_req_addr, er[39:8]);
          check_eq("req_len", rd_req_len, er[7:0]);
        end
        a_cap = rd_req_addr;
        l_cap = rd_req_len;
        if (stall_once > 0) begin
          weight_buffer_ready = 1'b0;
          for (int i = 0; i < stall_once; i++) begin
            @(negedge system_clk);
            check_eq("hold_valid", rd_req_valid, 1'b1);
            check_eq("hold_addr", rd_req_addr, a_cap);
            check_eq("hold_len", rd_req_len, l_cap);
          end
          weight_buffer_ready = 1'b1;
          stall_once = 0;
        end
        rd_req_ready = 1'b1;
        @(negedge system_clk);
        rd_req_ready = 1'b0;
        n = int'(l_cap) + 1;
        repeat ($urandom_range(0, 2)) @(negedge system_clk);
        for (int i = 0; i < n; i++) begin
          if (abort) break;
          if ($urandom_range(0, 7) == 0) begin
            rd_data_valid = 1'b0;
            @(negedge system_clk);
            if (abort) break;
          end
          d = rand_word();
          rd_data       = d;
          rd_data_valid = 1'b1;
          rd_data_last  = (early_last >= 0) ? (i == early_last) : (i == n - 1);
          exp_data.push_back(d);
          check_eq("one_outstanding", rd_req_valid, 1'b0);
          @(negedge system_clk);
        end
        rd_data_valid = 1'b0;
        rd_data_last  = 1'b0;
      end
    end
  end

  // Runs one fetch task. inject_cyc>=0 pulses a stray start mid-task;
  // drop_at>0 pulls weight_buffer_ready low for 20 cycles after that many beats.
  task automatic run_task(input logic [31:0] base, input int wc, input int inject_cyc,
                          input int drop_at, input bit exp_err);
    int rem, b, beats0, done0, cyc, busy_cyc, lowc;
    logic [31:0] a;
    bit got_done, dropped, wait_req;
    rem = wc;
    a   = base;
    while (rem > 0) begin
      b = (rem > 64) ? 64 : rem;
      exp_req.push_back({a, 8'(b - 1)});
      a   = a + 32'(b * 64);
      rem = rem - b;
    end
    beats0 = wb_beats;
    done0  = done_count;
    @(negedge system_clk); #1;
    start = 1'b1; base_addr = base; word_count = 24'(wc);
    @(negedge system_clk); #1;
    start = 1'b0; base_addr = '0; word_count = '0;
    check_eq("err_cleared", protocol_error, 1'b0);
    cyc = 0; busy_cyc = 0; lowc = 0;
    got_done = 1'b0; dropped = 1'b0; wait_req = 1'b0;
    while (!got_done && cyc < 2000) begin
      if (busy) busy_cyc++;
      if (done) begin
        got_done = 1'b1;
        check_eq("done_with_last_beat", weight_and_bias_valid, (wc != 0));
        check_eq("beat_count", wb_beats - beats0, wc);
        check_eq("data_drained", exp_data.size(), 0);
      end
      if (cyc == inject_cyc) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; word_count = 24'd3;
      end else begin
        start = 1'b0;
      end
      if (lowc > 0) begin
        check_eq("no_req_while_full", rd_req_valid, 1'b0);
        lowc--;
        if (lowc == 0) begin
          weight_buffer_ready = 1'b1;
          wait_req = 1'b1;
        end
      end else if (wait_req) begin
        check_eq("req_after_ready", rd_req_valid, 1'b1);
        wait_req = 1'b0;
      end else if (drop_at > 0 && !dropped && (wb_beats - beats0) == drop_at) begin
        weight_buffer_ready = 1'b0;
        dropped = 1'b1;
        lowc = 20;
      end
      if (!got_done) begin
        @(negedge system_clk); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check_eq("done_seen", got_done, 1'b1);
    check_eq("reqs_drained", exp_req.size(), 0);
    check_eq("protocol_error", protocol_error, exp_err);
    if (wc == 0) check_eq("busy_cycles_zero_len", busy_cyc, 1);
    @(negedge system_clk); #1;
    check_eq("idle_after_done", busy, 1'b0);
    check_eq("done_single", done_count - done0, 1);
    $display("task base=%h words=%0d beats=%0d cycles=%0d", base, wc, wb_beats - beats0, cyc);
  endtask

  // Aborts a 64-word task with reset partway through its data phase.
  task automatic reset_mid_data();
    int b0, d0, t;
    exp_req.push_back({32'h4000_0000, 8'd63});
    b0 = wb_beats;
    d0 = done_count;
    @(negedge system_clk); #1;
    start = 1'b1; base_addr = 32'h4000_0000; word_count = 24'd64;
    @(negedge system_clk); #1;
    start = 1'b0;
    t = 0;
    while ((wb_beats - b0) < 20 && t < 500) begin
      @(negedge system_clk); #1;
      t++;
    end
    check_eq("reset_reached_data", ((wb_beats - b0) >= 20), 1'b1);
    system_rst = 1'b1;
    abort = 1'b1;
    @(negedge system_clk); #1;
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_wb_valid", weight_and_bias_valid, 1'b0);
    check_eq("rst_req_valid", rd_req_valid, 1'b0);
    check_eq("rst_done", done, 1'b0);
    repeat (3) @(negedge system_clk);
    #1;
    system_rst = 1'b0;
    exp_data.delete();
    exp_req.delete();
    abort = 1'b0;
    repeat (6) @(negedge system_clk);
    #1;
    check_eq("no_done_after_reset", done_count - d0, 0);
    check_eq("idle_after_reset", busy, 1'b0);
    $display("task base=40000000 words=64 aborted by reset after %0d beats", wb_beats - b0);
  endtask

  initial begin : main
    system_rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    weight_buffer_ready = 1'b1;
    repeat (3) @(negedge system_clk);
    #1;
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_err", protocol_error, 1'b0);
    check_eq("reset_req_valid", rd_req_valid, 1'b0);
    check_eq("reset_req_addr", rd_req_addr, 32'h0);
    check_eq("reset_wb_valid", weight_and_bias_valid, 1'b0);
    check_eq("reset_wb_data", weight_and_bias_data, 512'h0);
    system_rst = 1'b0;
    @(negedge system_clk); #1;

    run_task(32'h1000_0000, 200, -1, 0, 1'b0);
    run_task(32'h2000_0000, 128, -1, 64, 1'b0);
    stall_once = 5;
    run_task(32'h0000_4000, 70, -1, 0, 1'b0);
    run_task(32'h0000_1234, 0, -1, 0, 1'b0);
    early_last = 10;
    run_task(32'h3000_0000, 64, -1, 0, 1'b1);
    early_last = -1;
    run_task(32'h3000_0000, 3, -1, 0, 1'b0);
    reset_mid_data();
    run_task(32'h5000_0000, 5, -1, 0, 1'b0);
    run_task(32'h1000_0000, 200, 30, 0, 1'b0);
    run_task(32'hFFFF_F000, 100, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/weight_fetch_controller.md
Name: weight_fetch_controller

Overview:
- Transmit side of the weight/bias path: fetches packed 512-bit weight/bias words from external memory and writes them into the weight buffer FIFO over weight_and_bias_valid/data.
- The weight buffer has no per-beat ready. Flow control is coarse: a read burst is issued only while weight_buffer_ready (FIFO below almost-full) is high.
- Sits between the layer scheduler (start/done), the memory read port, and the weight buffer.

Parameters:
- ADDR_WIDTH, 32, byte address width of memory read port
- MEM_DATA_WIDTH, 512, memory word width; bytes per word = MEM_DATA_WIDTH/8
- BURST_LEN, 64, max beats per read burst; must be ≤ FIFO slack above almost-full threshold (256)
- LEN_WIDTH, 8, width of rd_req_len; must hold BURST_LEN-1
- CNT_WIDTH, 24, width of word_count

Ports:
- system_clk  in  1  single clock
- system_rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse: begin a fetch task
- base_addr  in  ADDR_WIDTH  byte address of first word, sampled on accepted start
- word_count  in  CNT_WIDTH  number of MEM_DATA_WIDTH words to fetch, sampled on accepted start
- busy  out  1  high while a task is active
- done  out  1  one-cycle pulse at task completion
- protocol_error  out  1  sticky error flag, cleared on accepted start
- rd_req_valid  out  1  burst request valid
- rd_req_ready  in  1  memory accepts request
- rd_req_addr  out  ADDR_WIDTH  burst start byte address
- rd_req_len  out  LEN_WIDTH  beats-1
- rd_data  in  MEM_DATA_WIDTH  read data beat
- rd_data_valid  in  1  read beat valid (no backpressure)
- rd_data_last  in  1  last beat of burst
- weight_and_bias_data  out  MEM_DATA_WIDTH  word to weight buffer
- weight_and_bias_valid  out  1  write enable to weight buffer
- weight_buffer_ready  in  1  weight buffer below almost-full

Behaviour:
- Reset (system_rst=1 at clock edge): state=IDLE, all outputs 0, counters/address cleared. Reset mid-task aborts with no done pulse.
- States: IDLE, REQ, DATA, DONE. busy = (state != IDLE).
- IDLE:
  - start=1 latches base_addr into cur_addr and word_count into remaining, and clears protocol_error.
  - word_count==0 → DONE; else → REQ.
  - start outside IDLE is ignored.
- REQ:
  - When weight_buffer_ready=1 and rd_req_valid=0, assert rd_req_valid with rd_req_addr=cur_addr and rd_req_len=min(BURST_LEN,remaining)-1. Latch burst=min(BURST_LEN,remaining).
  - Once asserted, valid/addr/len are held stable until rd_req_ready=1, even if weight_buffer_ready drops.
  - Handshake cycle → DATA, beat_cnt=0, rd_req_valid deasserts next cycle.
- DATA:
  - Each rd_data_valid beat is registered: next cycle weight_and_bias_data=rd_data, weight_and_bias_valid=1. Latency exactly 1 cycle; otherwise weight_and_bias_valid=0.
  - beat_cnt increments per beat. The beat with beat_cnt==burst-1 closes the burst:
    - remaining -= burst
    - cur_addr += burst*(MEM_DATA_WIDTH/8), modulo 2^ADDR_WIDTH
    - → DONE if remaining becomes 0, else → REQ.
  - rd_data_last must coincide with the closing beat. If last arrives early or is missing on the closing beat, set protocol_error. The beat count alone governs burst closure.
- DONE: done=1 for exactly one cycle, coincident with the final weight_and_bias_valid (or the cycle after start for word_count=0) → IDLE.
- rd_data_valid in IDLE or REQ: beat dropped, protocol_error set.
- Only one burst outstanding at a time. Next request not issued before the previous burst's closing beat.
- weight_buffer_ready is checked only before raising rd_req_valid. In-flight beats are always forwarded, never dropped.

Test Plan:
- base_addr=0x1000_0000, word_count=200, ready always 1 → four requests (addr,len) = (0x10000000,63), (0x10001000,63), (0x10002000,63), (0x10003000,7); 200 weight_and_bias_valid beats, data in order, each 1 cycle after rd_data_valid; done once, with the 200th beat.
- weight_buffer_ready=0 after first burst for 20 cycles → no rd_req_valid for those cycles; ready→1 → second request issued next cycle. Separately, ready drops while rd_req_valid=1 and rd_req_ready=0 for 5 cycles → valid/addr/len held constant.
- word_count=0 → done pulses the cycle after start; rd_req_valid never asserts; busy high for exactly 1 cycle.
- rd_data_last on beat 10 of a 64-beat burst → protocol_error=1 and stays set; burst still closes after 64 beats; next start clears protocol_error.
- system_rst asserted mid-DATA of a 64-beat burst → next cycle busy=0, valid outputs 0, no done. New start with word_count=5 completes normally with a single request of len=4.
- start pulsed while busy → ignored; address sequence and beat count of the running task unchanged.
